// File: rtl/expr_unpack_pkg.sv
// Shared constants for the 90-bit packed-result unpacker: field geometry,
// signedness and the stream FSM state type.
package expr_unpack_pkg;

    localparam int NUM_FIELDS = 18;
    localparam int BUS_W      = 90;
    localparam int IDX_W      = 5;
    localparam int MAX_FW     = 6;

    // Widths cycle 4,5,6; fields are packed from bit BUS_W-1 downward.
    localparam int FIELD_W [NUM_FIELDS] = '{
        4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6
    };
    localparam int FIELD_LSB [NUM_FIELDS] = '{
        86, 81, 75, 71, 66, 60, 56, 51, 45, 41, 36, 30, 26, 21, 15, 11, 6, 0
    };
    localparam bit FIELD_SGN [NUM_FIELDS] = '{
        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1
    };

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/expr_field_extract.sv
// Combinational field select: picks field idx out of the held word and sign-
// or zero-extends it to OUT_W. Parity output exists with EXPR_UNPACK_PARITY_EN.
module expr_field_extract
    import expr_unpack_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [BUS_W-1:0] word,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] field
`ifdef EXPR_UNPACK_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [IDX_W-1:0]  fi;
    logic [BUS_W-1:0]  shifted;
    logic [MAX_FW-1:0] raw;
    logic              msb;
    logic              sign;
    int                fw;

    always_comb begin
        fi      = (idx < IDX_W'(NUM_FIELDS)) ? idx : '0;
        fw      = FIELD_W[fi];
        shifted = word >> FIELD_LSB[fi];
        raw     = '0;
        msb     = 1'b0;
        for (int b = 0; b < MAX_FW; b++) begin
            if (b < fw) raw[b] = shifted[b];
            if (b == fw - 1) msb = shifted[b];
        end
        sign  = FIELD_SGN[fi] && msb;
        field = OUT_W'(raw);
        // Fill everything above the field's own width with the sign bit.
        for (int b = 0; b < OUT_W; b++) begin
            if (sign && b >= fw) field[b] = 1'b1;
        end
    end

`ifdef EXPR_UNPACK_PARITY_EN
    assign parity = ^raw;
`endif

endmodule

// File: rtl/expr_unpack_stream.sv
// Accepts one 90-bit packed result word and streams its 18 fields, one per
// out handshake. Optional out_parity port under EXPR_UNPACK_PARITY_EN.
module expr_unpack_stream
    import expr_unpack_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
`ifdef EXPR_UNPACK_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BUS_W-1:0] hold_q, hold_d;
    logic [OUT_W-1:0] field;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d  = in_data;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                // No new word in the last-beat cycle; IDLE takes it next.
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef EXPR_UNPACK_PARITY_EN
    logic parity;

    expr_field_extract #(.OUT_W(OUT_W)) u_extract (
        .word   (hold_q),
        .idx    (idx_q),
        .field  (field),
        .parity (parity)
    );

    assign out_parity = out_valid & parity;
`else
    expr_field_extract #(.OUT_W(OUT_W)) u_extract (
        .word  (hold_q),
        .idx   (idx_q),
        .field (field)
    );
`endif

    // Outputs are forced to zero whenever nothing is being offered.
    assign out_data = out_valid ? field : '0;
    assign out_idx  = out_valid ? idx_q : '0;
    assign out_last = out_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_expr_unpack_stream.sv
// Directed bench for expr_unpack_stream: table of per-beat expectations for
// four words, plus stall, mid-word reset and back-to-back sequences.
module tb_expr_unpack_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [4:0]  out_idx;
    logic        out_last;
`ifdef EXPR_UNPACK_PARITY_EN
    logic        out_parity;
`endif

    always #5 clk = ~clk;

    expr_unpack_stream #(.OUT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef EXPR_UNPACK_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    typedef struct {
        int         slot;
        int         idx;
        logic [7:0] data;
        logic       last;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_data [4][18];
    logic [4:0] cap_idx  [4][18];
    logic       cap_last [4][18];
    logic       cap_par  [4][18];
    vec_t       vecs [72];
    logic [89:0] words [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Offer one word, then collect its 18 beats with out_ready high.
    task automatic send_word(input logic [89:0] w, input int slot);
        int guard;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_wait", 32'(guard < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom()};
        for (int k = 0; k < 18; k++) begin
            guard = 0;
            while (!out_valid && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                chk("beat_timeout", 32'd0, 32'd1);
                break;
            end
            cap_data[slot][k] = out_data;
            cap_idx[slot][k]  = out_idx;
            cap_last[slot][k] = out_last;
`ifdef EXPR_UNPACK_PARITY_EN
            cap_par[slot][k]  = out_parity;
`else
            cap_par[slot][k]  = 1'b0;
`endif
            @(negedge clk);
        end
        chk("post_word_out_valid", 32'(out_valid), 32'd0);
        chk("post_word_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ones_pat [6];
        logic [89:0] w;
        int guard, beats, cyc, hs1, hs2, nhs;

        ones_pat = '{8'h0F, 8'h1F, 8'h3F, 8'hFF, 8'hFF, 8'hFF};
        words[0] = '1;
        w = '0; w[89] = 1'b1; words[1] = w;
        w = '0; w[74] = 1'b1; words[2] = w;
        w = '0;
        w[80] = 1'b1; w[78] = 1'b1; w[76] = 1'b1;           // f2 = 101010
        w[69] = 1'b1; w[68] = 1'b1; w[67] = 1'b1; w[66] = 1'b1; // f4 = 01111
        w[65] = 1'b1;                                        // f5 = 100000
        w[5] = 1'b1; w[4] = 1'b1; w[3] = 1'b1; w[2] = 1'b1; w[1] = 1'b1; // f17 = 111110
        words[3] = w;

        for (int k = 0; k < 18; k++) begin
            vecs[k]      = '{0, k, ones_pat[k % 6], k == 17};
            vecs[18 + k] = '{1, k, (k == 0) ? 8'h08 : 8'h00, k == 17};
            vecs[36 + k] = '{2, k, (k == 3) ? 8'hF8 : 8'h00, k == 17};
            vecs[54 + k] = '{3, k,
                             (k == 2)  ? 8'h2A :
                             (k == 4)  ? 8'h0F :
                             (k == 5)  ? 8'hE0 :
                             (k == 17) ? 8'hFE : 8'h00, k == 17};
        end

        rst_n = 1'b0; in_valid = 1'b0; in_data = '1; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        for (int s = 0; s < 4; s++) send_word(words[s], s);

        for (int i = 0; i < 72; i++) begin
            chk($sformatf("data_w%0d_i%0d", vecs[i].slot, vecs[i].idx),
                32'(cap_data[vecs[i].slot][vecs[i].idx]), 32'(vecs[i].data));
            chk($sformatf("idx_w%0d_i%0d", vecs[i].slot, vecs[i].idx),
                32'(cap_idx[vecs[i].slot][vecs[i].idx]), 32'(vecs[i].idx));
            chk($sformatf("last_w%0d_i%0d", vecs[i].slot, vecs[i].idx),
                32'(cap_last[vecs[i].slot][vecs[i].idx]), 32'(vecs[i].last));
        end
`ifdef EXPR_UNPACK_PARITY_EN
        chk("parity_i0", 32'(cap_par[0][0]), 32'd0);
        chk("parity_i1", 32'(cap_par[0][1]), 32'd1);
        chk("parity_i2", 32'(cap_par[0][2]), 32'd0);
`endif

        // Stall 5 cycles on idx 7 of an all-ones word.
        @(negedge clk);
        in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        guard = 0;
        while (out_idx != 5'd7 && guard < 50) begin @(negedge clk); guard++; end
        chk("stall_reach_idx7", 32'(guard < 50), 32'd1);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_idx", 32'(out_idx), 32'd7);
            chk("stall_data", 32'(out_data), 32'h1F);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_idx", 32'(out_idx), 32'd8);
        chk("resume_data", 32'(out_data), 32'h3F);
        guard = 0;
        while (out_valid && guard < 50) begin @(negedge clk); guard++; end
        chk("stall_drain", 32'(guard < 50), 32'd1);

        // Reset in the middle of a word, at idx 9.
        in_valid = 1'b1; in_data = '1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (out_idx != 5'd9 && guard < 50) begin @(negedge clk); guard++; end
        chk("mid_reset_reach_idx9", 32'(guard < 50), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_out_idx", 32'(out_idx), 32'd0);
        chk("mid_reset_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        chk("mid_reset_hold_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        send_word(words[1], 1);
        chk("post_reset_first_idx", 32'(cap_idx[1][0]), 32'd0);
        chk("post_reset_first_data", 32'(cap_data[1][0]), 32'h08);

        // Two words back to back with in_valid held high.
        in_valid = 1'b1; in_data = words[0]; out_ready = 1'b1;
        beats = 0; cyc = 0; nhs = 0; hs1 = 0; hs2 = 0;
        while (beats < 36 && cyc < 80) begin
            if (out_valid && out_ready) beats++;
            if (in_valid && in_ready) begin
                if (nhs == 0) hs1 = cyc; else hs2 = cyc;
                nhs++;
            end
            @(negedge clk);
            cyc++;
            if (nhs == 1) in_data = words[2];
            if (nhs >= 2) in_valid = 1'b0;
        end
        chk("b2b_beats", 32'(beats), 32'd36);
        chk("b2b_handshakes", 32'(nhs), 32'd2);
        chk("b2b_spacing", 32'(hs2 - hs1), 32'd19);
        @(negedge clk);
        chk("b2b_idle_after", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
